sram_controller: RTL

- Sequences the external 16-bit SRAM on behalf of the ARM pipeline's MEM stage.
- Turns one 32-bit load/store into two 16-bit SRAM accesses, low half first, then high half. Each half is held for a fixed number of wait cycles to cover the SRAM's 30 ns read delay.
- Drives `ready` low while an access is in progress; the hazard/freeze logic stalls the pipeline on `ready`=0.

---
 rtl/sram_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// sram_controller: sequences a 16-bit external SRAM for 32-bit MEM-stage loads/stores.
// Each access is split into a low half then a high half, each held WAIT_CYCLES cycles.
// Optional feature macro: SRAM_READ_BUFFER_EN (one-entry read buffer, 1-cycle read hits).
module sram_controller #(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [31:0]       address,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    inout  logic [DATA_W-1:0] sram_dq,
    output logic              sram_we_en
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]  cnt;
    logic              last_cycle;
    logic              lat_wr;
    logic [ADDR_W-2:0] lat_pair;   // word index truncated; bit 0 of sram_addr selects the half
    logic [31:0]       lat_wdata;
    logic [ADDR_W-2:0] req_pair;
    logic              req;
    logic              buf_hit;
    logic              dq_oe;
    logic [DATA_W-1:0] dq_out;

    assign req        = wr_en | rd_en;
    assign last_cycle = (cnt == CNT_LAST);
    assign req_pair   = (ADDR_W-1)'((address - BASE_ADDR) >> 2);

`ifdef SRAM_READ_BUFFER_EN
    logic        buf_valid;
    logic [31:0] buf_word;
    logic [31:0] buf_data;
    logic [31:0] req_word;

    assign req_word = (address - BASE_ADDR) >> 2;
    assign buf_hit  = buf_valid && (buf_word == req_word);
`else
    assign buf_hit  = 1'b0;
`endif

    assign sram_dq = dq_oe ? dq_out : 'z;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and SRAM bus / handshake outputs.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        sram_addr  = '0;
        sram_we_en = 1'b1;
        dq_oe      = 1'b0;
        dq_out     = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = (!wr_en && buf_hit) ? DONE : LOW;
                end else begin
                    ready = 1'b1;
                end
            end
            LOW: begin
                sram_addr  = {lat_pair, 1'b0};
                sram_we_en = ~lat_wr;
                dq_oe      = lat_wr;
                dq_out     = lat_wdata[DATA_W-1:0];
                if (last_cycle) begin
                    next_state = HIGH;
                end
            end
            HIGH: begin
                sram_addr  = {lat_pair, 1'b1};
                sram_we_en = ~lat_wr;
                dq_oe      = lat_wr;
                dq_out     = lat_wdata[31:DATA_W];
                if (last_cycle) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latch, phase wait counter, read capture and optional read buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            lat_wr    <= 1'b0;
            lat_pair  <= '0;
            lat_wdata <= '0;
            rd_data   <= '0;
`ifdef SRAM_READ_BUFFER_EN
            buf_valid <= 1'b0;
            buf_word  <= '0;
            buf_data  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        lat_wr    <= wr_en;
                        lat_pair  <= req_pair;
                        lat_wdata <= wr_data;
`ifdef SRAM_READ_BUFFER_EN
                        if (wr_en) begin
                            buf_valid <= 1'b0;
                        end else if (buf_hit) begin
                            rd_data <= buf_data;
                        end else begin
                            // Entry is re-tagged now and marked valid once the SRAM read completes.
                            buf_valid <= 1'b0;
                            buf_word  <= req_word;
                        end
`endif
                    end
                end
                LOW: begin
                    if (last_cycle) begin
                        cnt <= '0;
                        if (!lat_wr) begin
                            rd_data[DATA_W-1:0] <= sram_dq;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (last_cycle) begin
                        cnt <= '0;
                        if (!lat_wr) begin
                            rd_data[31:DATA_W] <= sram_dq;
`ifdef SRAM_READ_BUFFER_EN
                            buf_valid <= 1'b1;
                            buf_data  <= {sram_dq, rd_data[DATA_W-1:0]};
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
